// File: rtl/inv_shift_rows_seq_pkg.sv
// Shared constants, FSM encoding and row<->state byte mapping helpers for the
// sequential (inverse) ShiftRows block.
package inv_shift_rows_seq_pkg;

  localparam int STATE_W  = 128;
  localparam int ROW_W    = 32;
  localparam int BYTE_W   = 8;
  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } fsm_e;

  // Byte s_(r + 4c) sits at the top of the state word, column-major.
  function automatic int byte_msb(input logic [1:0] r, input int c);
    return STATE_W - 1 - BYTE_W * (NUM_ROWS * c + int'(r));
  endfunction

  function automatic logic [ROW_W-1:0] get_row(input logic [STATE_W-1:0] st,
                                               input logic [1:0]         r);
    logic [ROW_W-1:0] row;
    row = '0;
    for (int c = 0; c < NUM_COLS; c++)
      row[ROW_W-1-BYTE_W*c -: BYTE_W] = st[byte_msb(r, c) -: BYTE_W];
    return row;
  endfunction

  function automatic logic [STATE_W-1:0] set_row(input logic [STATE_W-1:0] st,
                                                 input logic [1:0]         r,
                                                 input logic [ROW_W-1:0]   row);
    logic [STATE_W-1:0] res;
    res = st;
    for (int c = 0; c < NUM_COLS; c++)
      res[byte_msb(r, c) -: BYTE_W] = row[ROW_W-1-BYTE_W*c -: BYTE_W];
    return res;
  endfunction

endpackage

// File: rtl/inv_shift_rows_seq_rotr32.sv
// Combinational 32-bit byte rotator (right by k bytes).
// With ISR_FWD_MODE_EN defined, dir_left selects a left rotate instead.
module rotr32
  import inv_shift_rows_seq_pkg::*;
(
`ifdef ISR_FWD_MODE_EN
  input  logic             dir_left,
`endif
  input  logic [ROW_W-1:0] w,
  input  logic [1:0]       k,
  output logic [ROW_W-1:0] y
);

  logic [1:0]         amt;
  logic [2*ROW_W-1:0] dbl;

  always_comb begin
`ifdef ISR_FWD_MODE_EN
    // Left by k == right by (4-k) mod 4.
    amt = dir_left ? (2'd0 - k) : k;
`else
    amt = k;
`endif
    dbl = {w, w} >> {amt, 3'b000};
    y   = dbl[ROW_W-1:0];
  end

endmodule

// File: rtl/inv_shift_rows_seq.sv
// Sequential inverse ShiftRows: one row rotated per cycle through a shared rotator.
// Optional ISR_FWD_MODE_EN adds a mode port selecting forward (left) rotation.
module inv_shift_rows_seq
  import inv_shift_rows_seq_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [STATE_W-1:0] in_state,
`ifdef ISR_FWD_MODE_EN
  input  logic               mode,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] out_state
);

  fsm_e               fsm_q, fsm_d;
  logic [1:0]         cnt_q, cnt_d;
  logic [STATE_W-1:0] state_q, state_d;
  logic [ROW_W-1:0]   row_sel, row_rot;
`ifdef ISR_FWD_MODE_EN
  logic               mode_q, mode_d;
`endif

  assign row_sel = get_row(state_q, cnt_q);

  rotr32 u_rot (
`ifdef ISR_FWD_MODE_EN
    .dir_left (mode_q),
`endif
    .w        (row_sel),
    .k        (cnt_q),
    .y        (row_rot)
  );

  always_comb begin
    fsm_d     = fsm_q;
    cnt_d     = cnt_q;
    state_d   = state_q;
`ifdef ISR_FWD_MODE_EN
    mode_d    = mode_q;
`endif
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (fsm_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_d = in_state;
          cnt_d   = 2'd0;
`ifdef ISR_FWD_MODE_EN
          mode_d  = mode;
`endif
          fsm_d   = ST_BUSY;
        end
      end
      ST_BUSY: begin
        state_d = set_row(state_q, cnt_q, row_rot);
        cnt_d   = cnt_q + 2'd1;  // 3 -> 0 wrap coincides with leaving BUSY
        if (cnt_q == 2'd3) fsm_d = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) fsm_d = ST_IDLE;
      end
      default: fsm_d = ST_IDLE;
    endcase
  end

  assign out_state = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q   <= ST_IDLE;
      cnt_q   <= 2'd0;
      state_q <= '0;
`ifdef ISR_FWD_MODE_EN
      mode_q  <= 1'b0;
`endif
    end else begin
      fsm_q   <= fsm_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
`ifdef ISR_FWD_MODE_EN
      mode_q  <= mode_d;
`endif
    end
  end

endmodule

// File: tb/tb_inv_shift_rows_seq.sv
// Self-checking bench for inv_shift_rows_seq: directed cases plus 1000 random
// states with random backpressure against a byte-array ShiftRows model.
module tb_inv_shift_rows_seq;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_state = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_state;
  logic         mode = 1'b0;

  int n_assert = 0;
  int n_fail   = 0;

  localparam logic [127:0] VEC_IN  = 128'h00112233_44556677_8899aabb_ccddeeff;
  localparam logic [127:0] VEC_INV = 128'h00ddaa77_4411eebb_885522ff_cc996633;
  localparam logic [127:0] VEC_FWD = 128'h0055aaff_4499ee33_88dd2277_cc1166bb;

  always #5 clk = ~clk;

  inv_shift_rows_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_state  (in_state),
`ifdef ISR_FWD_MODE_EN
    .mode      (mode),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_state (out_state)
  );

  // Reference: row r, new column c takes old column (c - r) mod 4 (right
  // rotate); forward mode takes (c + r) mod 4.
  function automatic logic [127:0] ref_model(input logic [127:0] x, input bit fwd);
    logic [7:0]   ib [16];
    logic [7:0]   ob [16];
    logic [127:0] res;
    int           src;
    for (int i = 0; i < 16; i++) ib[i] = x[127-8*i -: 8];
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        src = fwd ? (c + r) % 4 : (c - r + 4) % 4;
        ob[r + 4*c] = ib[r + 4*src];
      end
    res = '0;
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = ob[i];
    return res;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one state through; bp = DONE cycles held with out_ready=0.
  // strict adds latency and per-cycle hold checks.
  task automatic run_one(input string tag, input logic [127:0] din, input bit md,
                         input int bp, input bit strict);
    logic [127:0] exp;
    int           n;
    exp = ref_model(din, md);
    n = 0;
    while (!in_ready && n < 50) begin tick(); n++; end
    chk({tag, "_in_ready"}, in_ready, 1);
    in_valid = 1'b1;
    in_state = din;
    mode     = md;
    tick();
    in_valid = 1'b0;
    in_state = {$urandom, $urandom, $urandom, $urandom};
    mode     = 1'($urandom);
    n = 0;
    while (!out_valid && n < 50) begin
      if (!strict) out_ready = 1'($urandom);
      tick();
      n++;
    end
    chk({tag, "_out_valid"}, out_valid, 1);
    if (strict) chk({tag, "_latency"}, n, 4);
    out_ready = 1'b0;
    for (int i = 0; i < bp; i++) begin
      tick();
      if (strict) begin
        chk({tag, "_hold_valid"}, out_valid, 1);
        chk({tag, "_hold_ready"}, in_ready, 0);
        chk({tag, "_hold_state"}, out_state, exp);
      end
    end
    chk({tag, "_result"}, out_state, exp);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_post_valid"}, out_valid, 0);
    if (strict) chk({tag, "_post_ready"}, in_ready, 1);
  endtask

  initial begin : main
    logic [127:0] a, b;
    int           n;

    // Reset state, asynchronous
    #3;
    chk("rst_in_ready",  in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_state", out_state, '0);
    #10 rst_n = 1'b1;
    tick();

    // Known vector, and the model against the same vector
    chk("model_inv", ref_model(VEC_IN, 1'b0), VEC_INV);
    run_one("vec", VEC_IN, 1'b0, 0, 1'b1);
    n_assert++;
    assert (out_state === VEC_INV) else begin
      n_fail++;
      $error("FAIL vec_const: observed %h expected %h", out_state, VEC_INV);
    end

    // Backpressure for 10 cycles
    run_one("bp10", VEC_IN, 1'b0, 10, 1'b1);

    // in_valid held with new data while busy: second state waits for IDLE
    a = {$urandom, $urandom, $urandom, $urandom};
    b = {$urandom, $urandom, $urandom, $urandom};
    in_valid = 1'b1; in_state = a;
    tick();
    in_state = b;
    n = 0;
    while (!out_valid && n < 50) begin tick(); n++; end
    chk("ovl_lat", n, 4);
    tick(); tick();
    chk("ovl_first", out_state, ref_model(a, 1'b0));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("ovl_idle_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 50) begin tick(); n++; end
    chk("ovl_second_lat", n, 4);
    chk("ovl_second", out_state, ref_model(b, 1'b0));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Reset pulse while BUSY with cnt=2
    in_valid = 1'b1; in_state = VEC_IN;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy_in_ready",  in_ready, 1);
    chk("rst_busy_out_valid", out_valid, 0);
    chk("rst_busy_out_state", out_state, '0);
    #3 rst_n = 1'b1;
    tick();
    chk("rst_busy_idle_valid", out_valid, 0);
    run_one("after_rst", {$urandom, $urandom, $urandom, $urandom}, 1'b0, 1, 1'b1);

`ifdef ISR_FWD_MODE_EN
    chk("model_fwd", ref_model(VEC_IN, 1'b1), VEC_FWD);
    run_one("fwd", VEC_IN, 1'b1, 0, 1'b1);
    chk("fwd_const", out_state, VEC_FWD);
    run_one("fwd_back", VEC_FWD, 1'b0, 0, 1'b1);
    chk("fwd_back_const", out_state, VEC_IN);
`endif

    // Random states, random backpressure
    for (int i = 0; i < 1000; i++) begin
      bit md;
`ifdef ISR_FWD_MODE_EN
      md = 1'($urandom);
`else
      md = 1'b0;
`endif
      run_one("rand", {$urandom, $urandom, $urandom, $urandom}, md,
              int'($urandom_range(0, 3)), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
